branch_resolver: RTL and testbench
==================================

# branch_resolver

Decode-stage branch resolution unit: the consumer of the fetch stage's prediction and the producer of its redirect, flush and BTB-update inputs. It evaluates the conditional branch, JAL or JALR held in IF/ID, compares the architecturally correct next PC against the PC fetch actually issued, and requests a redirect on mismatch. It also registers BTB training writes and keeps saturating branch and mispredict performance counters.

## Interface
- CNT_W, 32, width of each performance counter
- i_clk  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_valid  in  1  IF/ID holds a real instruction
- i_stall  in  1  ID stalled (operands not ready / hazard); no resolution this cycle
- i_pc  in  32  PC of the IF/ID instruction
- i_instr  in  32  IF/ID instruction word
- i_pred_taken  in  1  BTB-hit flag captured with the instruction at fetch
- i_if_pc  in  32  PC currently presented by fetch (its speculative next PC for i_pc)
- i_rs1_data  in  32  forwarded rs1 value
- i_rs2_data  in  32  forwarded rs2 value
- o_redirect_valid  out  1  fetch must load o_redirect_pc this cycle
- o_redirect_pc  out  32  correct next PC
- o_flush  out  1  squash the wrong-path instruction being fetched; equals o_redirect_valid
- o_btb_update  out  1  one-cycle BTB write strobe
- o_btb_update_pc  out  32  branch PC to install
- o_btb_update_target  out  32  taken target to install
- o_branch_cnt  out  CNT_W  resolved control transfers
- o_mispred_cnt  out  CNT_W  redirects issued

## Operation
- Decode on i_instr[6:0]:
  - 1100011 is BRANCH. funct3 000 BEQ, 001 BNE, 100 BLT (signed), 101 BGE (signed), 110 BLTU, 111 BGEU. funct3 010/011 decode as non-control.
  - 1101111 is JAL, always taken.
  - 1100111 with funct3 000 is JALR, always taken.
  - Anything else is non-control.
- Immediates:
  - B-type: {imm[12],imm[10:5],imm[4:1],imm[11],0}, sign-extended.
  - J-type: {imm[20],imm[10:1],imm[11],imm[19:12],0}, sign-extended.
  - I-type: sign-extended.
- Targets:
  - Branch/JAL target = i_pc + imm.
  - JALR target = (i_rs1_data + imm) & ~1.
  - All additions are 32-bit modulo 2^32; overflow wraps silently.
- Resolve condition: resolve = i_valid & ~i_stall & ~shadow & is_control.
- actual_next = taken ? target : i_pc + 4.
- Mispredict = resolve & (actual_next != i_if_pc). This covers:
  - taken but not predicted;
  - predicted with the wrong target;
  - predicted taken but not taken.
- On mispredict: o_redirect_valid = 1, o_redirect_pc = actual_next, o_flush = 1. All three are combinational from the current inputs.
- BTB training:
  - If resolve & taken & (mispredict | ~i_pred_taken), register the pc/target pair.
  - Pulse o_btb_update for exactly one cycle on the following cycle.
  - Not-taken mispredicts cause no BTB write; fetch's BTB has no invalidate.
- shadow flag:
  - Set on any clock edge where o_redirect_valid = 1.
  - Cleared on the next edge.
  - While set, the IF/ID content is the flushed wrong-path slot and is never resolved.
- Counters:
  - o_branch_cnt += 1 per resolve.
  - o_mispred_cnt += 1 per mispredict.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous assert, active-low):
  - shadow = 0, both counters = 0.
  - o_btb_update = 0; o_btb_update_pc and o_btb_update_target = 0.
  - Combinational outputs are 0 whenever i_valid = 0.
- Redirect has 0-cycle latency: it is asserted in the same cycle the control instruction sits unstalled in ID. Fetch takes the new PC on the next edge.
- o_btb_update appears 1 cycle after the resolving cycle and lasts exactly 1 cycle.
- A stalled cycle produces no redirect, no BTB update and no counter change. The instruction is resolved on its first unstalled cycle.
- Back-to-back control instructions:
  - The second one is resolved only if the first did not redirect.
  - If the first redirected, the next cycle is a shadow cycle.
- A BTB update pending in the cycle of a new resolve is still emitted. A new update in the following cycle overwrites the register, one update per cycle maximum.
- Reset asserted mid-operation clears a pending BTB update and the shadow immediately; nothing is emitted after release.

## Test plan
- BEQ at pc 0x100, imm +0x40, rs1 = rs2 = 5, i_pred_taken = 0, i_if_pc = 0x104
  -> redirect to 0x140 and flush in the same cycle; next cycle o_btb_update with pc 0x100, target 0x140; both counters = 1.
- BNE at 0x200, rs1 = rs2, i_pred_taken = 1, i_if_pc = 0x180
  -> redirect to 0x204; no BTB update; mispred_cnt = 1.
- Correctly predicted JAL at 0x300, imm -0x100, i_if_pc = 0x200, i_pred_taken = 1
  -> no redirect, no update; branch_cnt increments.
- JALR rs1 = 0x1003, imm 0, i_if_pc = 0x0
  -> redirect to 0x1002 (bit 0 cleared); BTB update target 0x1002. Next cycle, with i_valid = 1 and a branch instruction present, no resolve occurs (shadow).
- BLT with rs1 = 0xFFFFFFFF, rs2 = 1 -> taken; the same operands with BLTU -> not taken. Hold i_stall = 1 for 3 cycles first -> no output until release.
- Force o_mispred_cnt to all-ones (CNT_W = 4, 15 mispredicts) then one more -> stays 0xF. Assert i_reset low mid-update -> o_btb_update = 0 immediately and counters cleared.

Source files
------------

// File: rtl/branch_resolver_if.sv
// Bundle between the ID stage and the branch resolver.
// Carries the IF/ID instruction/operands in, and redirect/BTB/perf results out.
interface branch_resolver_if #(
   parameter int CNT_W = 32
);
   logic             i_valid;
   logic             i_stall;
   logic [31:0]      i_pc;
   logic [31:0]      i_instr;
   logic             i_pred_taken;
   logic [31:0]      i_if_pc;
   logic [31:0]      i_rs1_data;
   logic [31:0]      i_rs2_data;
   logic             o_redirect_valid;
   logic [31:0]      o_redirect_pc;
   logic             o_flush;
   logic             o_btb_update;
   logic [31:0]      o_btb_update_pc;
   logic [31:0]      o_btb_update_target;
   logic [CNT_W-1:0] o_branch_cnt;
   logic [CNT_W-1:0] o_mispred_cnt;

   modport master (
      output i_valid, i_stall, i_pc, i_instr,
      output i_pred_taken, i_if_pc,
      output i_rs1_data, i_rs2_data,
      input  o_redirect_valid, o_redirect_pc, o_flush,
      input  o_btb_update, o_btb_update_pc,
      input  o_btb_update_target,
      input  o_branch_cnt, o_mispred_cnt
   );

   modport slave (
      input  i_valid, i_stall, i_pc, i_instr,
      input  i_pred_taken, i_if_pc,
      input  i_rs1_data, i_rs2_data,
      output o_redirect_valid, o_redirect_pc, o_flush,
      output o_btb_update, o_btb_update_pc,
      output o_btb_update_target,
      output o_branch_cnt, o_mispred_cnt
   );
endinterface

// File: rtl/branch_resolver.sv
// Decode-stage branch resolver: evaluates BRANCH/JAL/JALR, redirects fetch
// on mispredict, registers BTB training writes, counts branches/mispredicts.
module branch_resolver #(
   parameter int CNT_W = 32
) (
   input logic         i_clk,
   input logic         i_reset,
   branch_resolver_if.slave bus
);
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] imm_b;
   logic [31:0] imm_j;
   logic [31:0] imm_i;
   logic        is_br;
   logic        is_jal;
   logic        is_jalr;
   logic        is_ctrl;
   logic        cond;
   logic        taken;
   logic [31:0] target;
   logic [31:0] seq_pc;
   logic [31:0] actual_next;
   logic        resolve;
   logic        mispred;

   logic             shadow_q, shadow_d;
   logic             upd_q, upd_d;
   logic [31:0]      upd_pc_q, upd_pc_d;
   logic [31:0]      upd_tgt_q, upd_tgt_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] mp_cnt_q, mp_cnt_d;

   always_comb begin
      opcode = bus.i_instr[6:0];
      funct3 = bus.i_instr[14:12];
      imm_b = {{19{bus.i_instr[31]}}, bus.i_instr[31],
               bus.i_instr[7], bus.i_instr[30:25],
               bus.i_instr[11:8], 1'b0};
      imm_j = {{11{bus.i_instr[31]}}, bus.i_instr[31],
               bus.i_instr[19:12], bus.i_instr[20],
               bus.i_instr[30:21], 1'b0};
      imm_i = {{20{bus.i_instr[31]}}, bus.i_instr[31:20]};

      is_br   = 1'b0;
      is_jal  = 1'b0;
      is_jalr = 1'b0;
      unique case (1'b1)
         (opcode == OP_BRANCH):
            is_br = (funct3 != 3'b010) && (funct3 != 3'b011);
         (opcode == OP_JAL):
            is_jal = 1'b1;
         (opcode == OP_JALR):
            is_jalr = (funct3 == 3'b000);
         default: ;
      endcase

      cond = 1'b0;
      case (funct3)
         3'b000: cond = bus.i_rs1_data == bus.i_rs2_data;
         3'b001: cond = bus.i_rs1_data != bus.i_rs2_data;
         3'b100: cond = $signed(bus.i_rs1_data)
                        < $signed(bus.i_rs2_data);
         3'b101: cond = $signed(bus.i_rs1_data)
                        >= $signed(bus.i_rs2_data);
         3'b110: cond = bus.i_rs1_data < bus.i_rs2_data;
         3'b111: cond = bus.i_rs1_data >= bus.i_rs2_data;
         default: cond = 1'b0;
      endcase

      is_ctrl = is_br | is_jal | is_jalr;
      taken   = is_jal | is_jalr | (is_br & cond);

      target = '0;
      unique case (1'b1)
         is_jalr: target = (bus.i_rs1_data + imm_i) & ~32'd1;
         is_jal:  target = bus.i_pc + imm_j;
         default: target = bus.i_pc + imm_b;
      endcase

      seq_pc      = bus.i_pc + 32'd4;
      actual_next = taken ? target : seq_pc;

      // The slot after a redirect is the wrong-path fetch; never resolve it.
      resolve = bus.i_valid & ~bus.i_stall & ~shadow_q & is_ctrl;
      mispred = resolve & (actual_next != bus.i_if_pc);
   end

   assign bus.o_redirect_valid = mispred;
   assign bus.o_flush          = mispred;
   assign bus.o_redirect_pc    = mispred ? actual_next : '0;

   always_comb begin
      shadow_d = mispred;

      // Only taken transfers train; the BTB cannot forget a stale entry.
      upd_d     = resolve & taken & (mispred | ~bus.i_pred_taken);
      upd_pc_d  = upd_d ? bus.i_pc : upd_pc_q;
      upd_tgt_d = upd_d ? target   : upd_tgt_q;

      br_cnt_d = br_cnt_q;
      if (resolve && (br_cnt_q != CNT_MAX))
         br_cnt_d = br_cnt_q + 1'b1;

      mp_cnt_d = mp_cnt_q;
      if (mispred && (mp_cnt_q != CNT_MAX))
         mp_cnt_d = mp_cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         shadow_q  <= 1'b0;
         upd_q     <= 1'b0;
         upd_pc_q  <= '0;
         upd_tgt_q <= '0;
         br_cnt_q  <= '0;
         mp_cnt_q  <= '0;
      end else begin
         shadow_q  <= shadow_d;
         upd_q     <= upd_d;
         upd_pc_q  <= upd_pc_d;
         upd_tgt_q <= upd_tgt_d;
         br_cnt_q  <= br_cnt_d;
         mp_cnt_q  <= mp_cnt_d;
      end
   end

   assign bus.o_btb_update        = upd_q;
   assign bus.o_btb_update_pc     = upd_pc_q;
   assign bus.o_btb_update_target = upd_tgt_q;
   assign bus.o_branch_cnt        = br_cnt_q;
   assign bus.o_mispred_cnt       = mp_cnt_q;
endmodule

// File: tb/tb_branch_resolver.sv
// Testbench for branch_resolver: directed vector table plus
// hand-written sequences for shadow, stall, overwrite, saturation, reset.
module tb_branch_resolver;
   localparam int CW = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   exp_br;
   int   exp_mp;

   branch_resolver_if #(.CNT_W(CW)) bus ();

   branch_resolver #(.CNT_W(CW)) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] if_pc;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        pred;
      logic        res;
      logic        redir;
      logic [31:0] rpc;
      logic        upd;
      logic [31:0] upc;
      logic [31:0] utgt;
   } vec_t;

   vec_t tbl[15];

   function automatic logic [31:0] enc_b(
      input logic [2:0] f3, input logic [31:0] imm);
      return {imm[12], imm[10:5], 5'd2, 5'd1, f3,
              imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input logic [31:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12],
              5'd1, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_i(
      input logic [2:0] f3, input logic [31:0] imm,
      input logic [6:0] op);
      return {imm[11:0], 5'd1, f3, 5'd1, op};
   endfunction

   function automatic vec_t mk(
      input logic v, input logic [31:0] ins, input logic [31:0] pc,
      input logic [31:0] ifpc, input logic [31:0] a,
      input logic [31:0] b, input logic pr, input logic res,
      input logic rd, input logic [31:0] rpc, input logic up,
      input logic [31:0] upc, input logic [31:0] utg);
      vec_t t;
      t.valid = v;  t.instr = ins; t.pc = pc; t.if_pc = ifpc;
      t.rs1 = a;    t.rs2 = b;     t.pred = pr; t.res = res;
      t.redir = rd; t.rpc = rpc;   t.upd = up;
      t.upc = upc;  t.utgt = utg;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h",
                  name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t, input logic stall);
      bus.i_valid      = t.valid;
      bus.i_stall      = stall;
      bus.i_instr      = t.instr;
      bus.i_pc         = t.pc;
      bus.i_if_pc      = t.if_pc;
      bus.i_rs1_data   = t.rs1;
      bus.i_rs2_data   = t.rs2;
      bus.i_pred_taken = t.pred;
   endtask

   task automatic idle();
      bus.i_valid      = 1'b0;
      bus.i_stall      = 1'b0;
      bus.i_instr      = 32'h0000_0013;
      bus.i_pc         = '0;
      bus.i_if_pc      = '0;
      bus.i_rs1_data   = '0;
      bus.i_rs2_data   = '0;
      bus.i_pred_taken = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   vec_t v;
   vec_t beq_upd;
   vec_t jal_upd;
   vec_t bne_mp;

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      idle();

      tbl[0]  = mk(1, enc_b(3'b000, 32'h40), 32'h100, 32'h104,
                   5, 5, 0, 1, 1, 32'h140, 1, 32'h100, 32'h140);
      tbl[1]  = mk(1, enc_b(3'b001, 32'h40), 32'h200, 32'h180,
                   7, 7, 1, 1, 1, 32'h204, 0, 0, 0);
      tbl[2]  = mk(1, enc_j(-32'sd256), 32'h300, 32'h200,
                   0, 0, 1, 1, 0, 0, 0, 0, 0);
      tbl[3]  = mk(1, enc_i(3'b000, 0, 7'b1100111), 32'h400, 32'h0,
                   32'h1003, 0, 0, 1, 1, 32'h1002, 1, 32'h400, 32'h1002);
      tbl[4]  = mk(1, enc_b(3'b100, 32'h10), 32'h500, 32'h504,
                   32'hFFFF_FFFF, 1, 0, 1, 1, 32'h510, 1, 32'h500, 32'h510);
      tbl[5]  = mk(1, enc_b(3'b110, 32'h10), 32'h500, 32'h504,
                   32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0, 0, 0);
      tbl[6]  = mk(1, enc_b(3'b101, -32'sd8), 32'h600, 32'h5F8,
                   1, 32'hFFFF_FFFF, 1, 1, 0, 0, 0, 0, 0);
      tbl[7]  = mk(1, enc_b(3'b111, -32'sd8), 32'h700, 32'h7F0,
                   1, 32'hFFFF_FFFF, 1, 1, 1, 32'h704, 0, 0, 0);
      tbl[8]  = mk(1, enc_b(3'b100, 32'h20), 32'h800, 32'h810,
                   1, 2, 1, 1, 1, 32'h820, 1, 32'h800, 32'h820);
      tbl[9]  = mk(1, enc_b(3'b010, 32'h20), 32'h900, 32'h1234,
                   1, 1, 0, 0, 0, 0, 0, 0, 0);
      tbl[10] = mk(1, enc_i(3'b000, 5, 7'b0010011), 32'hA00, 32'h1234,
                   0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[11] = mk(1, enc_i(3'b001, 0, 7'b1100111), 32'hB00, 32'h1234,
                   0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[12] = mk(1, enc_j(32'h20), 32'hFFFF_FFF0, 32'hFFFF_FFF4,
                   0, 0, 0, 1, 1, 32'h10, 1, 32'hFFFF_FFF0, 32'h10);
      tbl[13] = mk(0, enc_b(3'b000, 32'h40), 32'h100, 32'h104,
                   5, 5, 0, 0, 0, 0, 0, 0, 0);
      tbl[14] = mk(1, enc_i(3'b000, -32'sd4, 7'b1100111), 32'hC00,
                   32'h1FFC, 32'h2001, 0, 1, 1, 0, 0, 0, 0, 0);

      // Reset state
      #2;
      chk("rst_upd", {31'd0, bus.o_btb_update}, 0);
      chk("rst_upc", bus.o_btb_update_pc, 0);
      chk("rst_utg", bus.o_btb_update_target, 0);
      chk("rst_bcnt", {28'd0, bus.o_branch_cnt}, 0);
      chk("rst_mcnt", {28'd0, bus.o_mispred_cnt}, 0);
      chk("rst_redir", {31'd0, bus.o_redirect_valid}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      exp_br = 0;
      exp_mp = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         drive(tbl[i], 1'b0);
         #1;
         chk($sformatf("v%0d_redir", i),
             {31'd0, bus.o_redirect_valid}, {31'd0, tbl[i].redir});
         chk($sformatf("v%0d_flush", i),
             {31'd0, bus.o_flush}, {31'd0, tbl[i].redir});
         if (tbl[i].redir)
            chk($sformatf("v%0d_rpc", i),
                bus.o_redirect_pc, tbl[i].rpc);
         if (tbl[i].res) exp_br++;
         if (tbl[i].redir) exp_mp++;
         @(negedge clk);
         idle();
         #1;
         chk($sformatf("v%0d_upd", i),
             {31'd0, bus.o_btb_update}, {31'd0, tbl[i].upd});
         if (tbl[i].upd) begin
            chk($sformatf("v%0d_upc", i),
                bus.o_btb_update_pc, tbl[i].upc);
            chk($sformatf("v%0d_utg", i),
                bus.o_btb_update_target, tbl[i].utgt);
         end
         chk($sformatf("v%0d_bcnt", i),
             {28'd0, bus.o_branch_cnt}, exp_br);
         chk($sformatf("v%0d_mcnt", i),
             {28'd0, bus.o_mispred_cnt}, exp_mp);
      end

      // Shadow: JALR redirect, then a taken branch in the flushed slot
      do_reset();
      @(negedge clk);
      drive(tbl[3], 1'b0);
      #1;
      chk("sh_redir", {31'd0, bus.o_redirect_valid}, 1);
      chk("sh_rpc", bus.o_redirect_pc, 32'h1002);
      @(negedge clk);
      drive(tbl[0], 1'b0);
      #1;
      chk("sh_noredir", {31'd0, bus.o_redirect_valid}, 0);
      chk("sh_upd", {31'd0, bus.o_btb_update}, 1);
      chk("sh_utg", bus.o_btb_update_target, 32'h1002);
      @(negedge clk);
      #1;
      chk("sh_bcnt", {28'd0, bus.o_branch_cnt}, 1);
      chk("sh_upd_gone", {31'd0, bus.o_btb_update}, 0);
      chk("sh_redir2", {31'd0, bus.o_redirect_valid}, 1);
      chk("sh_rpc2", bus.o_redirect_pc, 32'h140);
      @(negedge clk);
      idle();
      #1;
      chk("sh_upd2", {31'd0, bus.o_btb_update}, 1);
      chk("sh_utg2", bus.o_btb_update_target, 32'h140);
      chk("sh_bcnt2", {28'd0, bus.o_branch_cnt}, 2);
      chk("sh_mcnt2", {28'd0, bus.o_mispred_cnt}, 2);

      // Stall: BLT held 3 cycles before release
      do_reset();
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         drive(tbl[4], 1'b1);
         #1;
         chk($sformatf("st%0d_redir", s),
             {31'd0, bus.o_redirect_valid}, 0);
         chk($sformatf("st%0d_upd", s), {31'd0, bus.o_btb_update}, 0);
         chk($sformatf("st%0d_bcnt", s), {28'd0, bus.o_branch_cnt}, 0);
      end
      @(negedge clk);
      drive(tbl[4], 1'b0);
      #1;
      chk("st_rel_redir", {31'd0, bus.o_redirect_valid}, 1);
      chk("st_rel_rpc", bus.o_redirect_pc, 32'h510);
      @(negedge clk);
      idle();
      #1;
      chk("st_rel_upd", {31'd0, bus.o_btb_update}, 1);
      chk("st_rel_bcnt", {28'd0, bus.o_branch_cnt}, 1);

      // Back-to-back correctly predicted-target but BTB-miss updates
      do_reset();
      beq_upd = mk(1, enc_b(3'b000, 32'h40), 32'h100, 32'h140,
                   3, 3, 0, 1, 0, 0, 1, 32'h100, 32'h140);
      jal_upd = mk(1, enc_j(32'h20), 32'h140, 32'h160,
                   0, 0, 0, 1, 0, 0, 1, 32'h140, 32'h160);
      @(negedge clk);
      drive(beq_upd, 1'b0);
      #1;
      chk("bb_redir0", {31'd0, bus.o_redirect_valid}, 0);
      @(negedge clk);
      drive(jal_upd, 1'b0);
      #1;
      chk("bb_redir1", {31'd0, bus.o_redirect_valid}, 0);
      chk("bb_upd1", {31'd0, bus.o_btb_update}, 1);
      chk("bb_upc1", bus.o_btb_update_pc, 32'h100);
      @(negedge clk);
      idle();
      #1;
      chk("bb_upd2", {31'd0, bus.o_btb_update}, 1);
      chk("bb_upc2", bus.o_btb_update_pc, 32'h140);
      chk("bb_utg2", bus.o_btb_update_target, 32'h160);
      chk("bb_bcnt", {28'd0, bus.o_branch_cnt}, 2);
      chk("bb_mcnt", {28'd0, bus.o_mispred_cnt}, 0);

      // Saturation: 16 mispredicts on a 4-bit counter
      do_reset();
      bne_mp = mk(1, enc_b(3'b001, 32'h40), 32'h200, 32'h180,
                  7, 7, 1, 1, 1, 32'h204, 0, 0, 0);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         drive(bne_mp, 1'b0);
         @(negedge clk);
         idle();
         #1;
         if (k == 14)
            chk("sat_mcnt15", {28'd0, bus.o_mispred_cnt}, 15);
      end
      chk("sat_mcnt_hold", {28'd0, bus.o_mispred_cnt}, 15);
      chk("sat_bcnt_hold", {28'd0, bus.o_branch_cnt}, 15);

      // Reset asserted while a BTB update is on the bus
      @(negedge clk);
      drive(beq_upd, 1'b0);
      @(negedge clk);
      idle();
      #1;
      chk("mr_upd_pre", {31'd0, bus.o_btb_update}, 1);
      rst_n = 1'b0;
      #1;
      chk("mr_upd", {31'd0, bus.o_btb_update}, 0);
      chk("mr_upc", bus.o_btb_update_pc, 0);
      chk("mr_utg", bus.o_btb_update_target, 0);
      chk("mr_bcnt", {28'd0, bus.o_branch_cnt}, 0);
      chk("mr_mcnt", {28'd0, bus.o_mispred_cnt}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("mr_post_upd", {31'd0, bus.o_btb_update}, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
